// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-port register file: two bypassed read ports, execute
//               and memory write ports, per-register pending scoreboard and a
//               sequential one-register-per-cycle clear engine.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int NREG   = 15,
    parameter int ID_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ID_W-1:0]   srcA,
    input  logic [ID_W-1:0]   srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              rdyA,
    output logic              rdyB,
    input  logic [ID_W-1:0]   dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [ID_W-1:0]   dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic              mark_en,
    input  logic [ID_W-1:0]   mark_id,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [ID_W-1:0] c_NREG_ID = ID_W'(NREG);
    localparam logic [ID_W-1:0] c_LAST    = ID_W'(NREG - 1);
    localparam logic [ID_W-1:0] c_ONE     = ID_W'(1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_CLEAR = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic              r_done;
    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_pend;

    logic              w_e_vld;
    logic              w_m_vld;
    logic              w_mark_vld;
    logic              w_in_clear;
    logic              w_last;

    logic [DATA_W-1:0] w_st_a;
    logic [DATA_W-1:0] w_st_b;
    logic              w_pd_a;
    logic              w_pd_b;
    logic              w_hit_ma;
    logic              w_hit_ea;
    logic              w_hit_mb;
    logic              w_hit_eb;

    // IDs at or above NREG (RNONE included) address nothing.
    assign w_e_vld    = (dstE < c_NREG_ID);
    assign w_m_vld    = (dstM < c_NREG_ID);
    assign w_mark_vld = mark_en && (mark_id < c_NREG_ID);
    assign w_in_clear = (r_state == c_CLEAR);
    assign w_last     = (r_ptr == c_LAST);

    // ------------------------------------------------------------------
    // Clear FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (clr_req) w_state_nxt = c_CLEAR;
            c_CLEAR: if (w_last)  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        clr_busy = (r_state == c_CLEAR);
        clr_done = r_done;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_in_clear && w_last;
            if (w_in_clear && !w_last) begin
                r_ptr <= r_ptr + c_ONE;
            end else begin
                r_ptr <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register array and pending scoreboard
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_pend <= '0;
        end else if (w_in_clear) begin
            for (int i = 0; i < NREG; i++) begin
                if (r_ptr == ID_W'(i)) begin
                    r_regs[i] <= '0;
                    r_pend[i] <= 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_m_vld && (dstM == ID_W'(i))) begin
                    r_regs[i] <= valM;
                end else if (w_e_vld && (dstE == ID_W'(i))) begin
                    r_regs[i] <= valE;
                end
                // A mark in the same cycle as a write keeps the register pending.
                if (w_mark_vld && (mark_id == ID_W'(i))) begin
                    r_pend[i] <= 1'b1;
                end else if ((w_m_vld && (dstM == ID_W'(i))) ||
                             (w_e_vld && (dstE == ID_W'(i)))) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports: stored value lookup, then M-over-E bypass
    // ------------------------------------------------------------------
    always_comb begin
        w_st_a = '0;
        w_st_b = '0;
        w_pd_a = 1'b0;
        w_pd_b = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (srcA == ID_W'(i)) begin
                w_st_a = r_regs[i];
                w_pd_a = r_pend[i];
            end
            if (srcB == ID_W'(i)) begin
                w_st_b = r_regs[i];
                w_pd_b = r_pend[i];
            end
        end
    end

    assign w_hit_ma = w_m_vld && (srcA == dstM);
    assign w_hit_ea = w_e_vld && (srcA == dstE);
    assign w_hit_mb = w_m_vld && (srcB == dstM);
    assign w_hit_eb = w_e_vld && (srcB == dstE);

    // Out-of-range sources see zero data and no pending bit, hence ready.
    always_comb begin
        valA = w_hit_ma ? valM : (w_hit_ea ? valE : w_st_a);
        valB = w_hit_mb ? valM : (w_hit_eb ? valE : w_st_b);
        rdyA = !w_pd_a || w_hit_ma || w_hit_ea;
        rdyB = !w_pd_b || w_hit_mb || w_hit_eb;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter NREG, default 15, number of registers, legal range 2..15.
REQ-003 SHALL have parameter ID_W, default 4, register-ID width; ID 2^ID_W-1 (0xF) is RNONE.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 srcA, srcB  in  ID_W each  read-port register IDs.
REQ-007 valA, valB  out  DATA_W each  read data, combinational.
REQ-008 rdyA, rdyB  out  1 each  operand-ready flags, combinational.
REQ-009 dstE / valE  in  ID_W / DATA_W  execute-stage write port.
REQ-010 dstM / valM  in  ID_W / DATA_W  memory-stage write port.
REQ-011 mark_en / mark_id  in  1 / ID_W  scoreboard: flag register mark_id as pending.
REQ-012 clr_req  in  1  request a sequential clear of all registers.
REQ-013 clr_busy  out  1  clear sequence in progress.
REQ-014 clr_done  out  1  one-cycle pulse when the clear sequence finishes.

Function
REQ-015 SHALL hold NREG registers of DATA_W bits plus one pending bit per register.
REQ-016 Write: dstE < NREG SHALL write valE; dstM < NREG SHALL write valM; IDs >= NREG (incl. RNONE) SHALL write nothing.
REQ-017 dstE == dstM (both valid) in the same cycle: valM SHALL win.
REQ-018 Read: valX SHALL equal valM if srcX == dstM (valid); else valE if srcX == dstE (valid); else stored value (same-cycle bypass, M over E).
REQ-019 srcX >= NREG SHALL give valX = 0 and rdyX = 1.
REQ-020 Any write to register i SHALL clear pending[i] at the edge.
REQ-021 mark_en with mark_id < NREG SHALL set pending[mark_id]; mark_id >= NREG SHALL be ignored.
REQ-022 Mark and write to the same register in one cycle: pending SHALL end set (mark wins); the data write still occurs.
REQ-023 rdyX SHALL be 1 when pending[srcX] == 0 or srcX is being written this cycle (bypass hit); else 0.
REQ-024 Clear FSM states: IDLE, CLEAR. IDLE->CLEAR when clr_req=1; register index ptr starts at 0.
REQ-025 In CLEAR, each cycle SHALL zero register ptr, clear pending[ptr], increment ptr; after ptr == NREG-1, SHALL return to IDLE.
REQ-026 Clear SHALL take exactly NREG cycles; clr_busy = 1 throughout CLEAR; clr_done = 1 in the first IDLE cycle after it.
REQ-027 During CLEAR, dstE/dstM writes and mark_en SHALL be ignored; clr_req SHALL be ignored; reads still bypass per REQ-018.
REQ-028 clr_req in the same cycle as writes, while IDLE: writes SHALL take effect, then CLEAR starts next cycle.

Reset
REQ-029 reset = 0 SHALL immediately, without waiting for a clock edge, zero all registers and pending bits, force IDLE, ptr = 0, clr_busy = 0, clr_done = 0.
REQ-030 reset asserted mid-clear SHALL abort the sequence with no clr_done pulse.
REQ-031 After reset deasserts, the first rising edge SHALL accept writes normally.

Verification
REQ-032 Write dstE=2 valE=0x11, dstM=2 valM=0x22 in one cycle -> next cycle, srcA=2 reads 0x22.
REQ-033 Bypass: reg3=0x5; dstE=3 valE=0xA, srcA=3 same cycle -> valA=0xA combinationally; dstM=3 valM=0xB also -> valA=0xB.
REQ-034 Scoreboard: mark_id=4 -> rdyA=0 for srcA=4; cycle with dstM=4 -> rdyA=1 same cycle, pending cleared after the edge; mark and write reg 4 together -> rdyA=0 after the edge.
REQ-035 Clear: regs loaded nonzero, clr_req for 1 cycle -> clr_busy high 15 cycles (NREG=15), writes ignored, all regs 0, clr_done pulses 1 cycle.
REQ-036 Async reset: reset low mid-clear, between clock edges -> regs 0, clr_busy 0 before the next edge, no clr_done.
REQ-037 RNONE/out-of-range: dstE=0xF, mark_id=0xF, srcB=0xF -> no state change, valB=0, rdyB=1.
